flit_deserializer: RTL and testbench
====================================

Name: flit_deserializer

Overview:
- Parametrised successor to the fixed 4-bit/31-beat TileLink flit deserializer in the chip-to-chip serial link.
- Assembles BEATS = ceil(OUT_W/FLIT_W) narrow beats into one OUT_W-bit word and presents it on a ready/valid output.
- The current generation's in_ready drops while a word waits at the output. This block double-buffers, so input assembly continues under output backpressure (zero-bubble).
- Adds selectable beat order and a synchronous flush of a partial frame.

Parameters:
- FLIT_W, 4, serial beat width in bits (>=1).
- OUT_W, 122, assembled word width in bits (>=FLIT_W).
- MSB_FIRST, 0, 0: beat 0 carries the least-significant slice; 1: beat 0 carries the most-significant slice.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_bits  in  FLIT_W  beat payload
- in_flush  in  1  discard partial frame
- out_valid  out  1  assembled word valid
- out_ready  in  1  consumer accepts word
- out_bits  out  OUT_W  assembled word
- busy  out  1  beat count != 0 or out_valid

Behaviour:
- Storage:
  - assembly buffer asm[BEATS*FLIT_W];
  - beat counter cnt, width clog2(BEATS) (min 1);
  - asm_full flag;
  - output register obuf[OUT_W] with flag out_valid.
- Reset values: cnt=0, asm_full=0, out_valid=0, obuf=0, so out_bits=0, in_ready=1, busy=0. asm contents are don't-care.
- in_ready = ~asm_full. Combinational from state only; no path from in_valid or out_ready.
- Placement on in fire:
  - LSB order: in_bits is written to asm slot cnt, bits [cnt*FLIT_W +: FLIT_W].
  - MSB order: in_bits is written to slot BEATS-1-cnt.
  - Other slots hold.
- Counter:
  - Increments on fire.
  - On fire with cnt==BEATS-1: cnt wraps to 0 and the frame is complete.
- Word mapping: word = asm with the completing beat merged in the same cycle, truncated to the low OUT_W bits. The top BEATS*FLIT_W-OUT_W pad bits are discarded:
  - LSB order: the pad is the upper bits of the last beat.
  - MSB order: the pad is the upper bits of beat 0.
- Frame completion, where drain = out_valid & out_ready:
  - If ~out_valid | drain: obuf <= word, out_valid stays or becomes 1 (latency: the word is visible the cycle after the last beat).
  - Otherwise: asm_full <= 1 and in_ready drops.
- Stall state (asm_full=1):
  - When drain occurs, obuf <= asm (truncated), out_valid stays 1, asm_full <= 0, and in_ready returns to 1 the next cycle.
- Drain with nothing pending: out_valid <= 0.
- Simultaneous drain and completion: the new word loads, out_valid stays 1, no bubble.
- Sustained throughput: one word per BEATS cycles, regardless of out_ready timing, provided the consumer drains within BEATS cycles.
- Flush:
  - in_flush=1 forces cnt <= 0.
  - A beat fired in the same cycle is discarded and does not complete a frame.
  - Flush does not affect asm_full, obuf or out_valid. A completed frame is never lost.
- out_bits is held stable while out_valid & ~out_ready (AXI/Decoupled stability rule).
- Reset mid-frame or mid-stall: everything returns to reset values next cycle; the partial and held words are dropped.
- Degenerate case BEATS==1: every fire completes a frame and cnt stays 0.

Decomposition:
- Package serdes_pkg:
  - function beats(out_w, flit_w) = ceil division;
  - function cnt_w(n) = max(1, clog2(n));
  - shared by the future serializer successor.
- Sub-module deser_out_stage:
  - single-entry ready/valid holding register (OUT_W-wide);
  - load/drain logic, out_valid, stability.
- The top module holds the counter, assembly buffer, asm_full and flush.

Test Plan:
1. FLIT_W=4, OUT_W=10, MSB_FIRST=0, out_ready=1. Beats 0xA, 0x5, 0xF. Expected: out_bits=0x35A one cycle after the third fire, in_ready constant 1.
2. Same configuration with MSB_FIRST=1. Beats 0xF, 0x5, 0xA. Expected: out_bits=0x35A (top two bits of beat 0 dropped).
3. Back-pressure, defaults (BEATS=31), out_ready=0. Send two full frames. Expected: first frame in obuf; in_ready goes 0 the cycle after the 62nd beat. Raising out_ready for one cycle yields frame 1, then frame 2 with out_valid continuously 1 and in_ready back to 1.
4. Flush, FLIT_W=4/OUT_W=10. Send 2 beats, then assert in_flush together with a third beat, then send 0x1, 0x2, 0x3. Expected: exactly one word, 0x321.
5. Streaming, defaults, in_valid=1 for 310 cycles, out_ready toggling 1/0. Expected: 10 words, no in_ready deassertion, payloads match the scoreboard.
6. Reset asserted with cnt=17 and out_valid=1. Expected: next cycle out_valid=0, busy=0, in_ready=1; the next 31 beats form a clean word.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared sizing helpers for the serial-link flit serializer/deserializer family.
package serdes_pkg;

    // Number of FLIT_W beats needed to carry an OUT_W word (ceiling division).
    function automatic int unsigned beats(input int unsigned out_w, input int unsigned flit_w);
        return (out_w + flit_w - 1) / flit_w;
    endfunction

    // Beat counter width; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/deser_out_stage.sv
// Single-entry ready/valid holding register for the assembled word.
module deser_out_stage #(
    parameter int unsigned OUT_W = 122
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [OUT_W-1:0] load_bits,
    output logic             accept,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_bits
);

    logic             valid_q;
    logic [OUT_W-1:0] bits_q;

    // A new word may enter when the register is empty or being drained this cycle.
    assign accept    = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_bits  = bits_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            bits_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            bits_q  <= load_bits;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/flit_deserializer.sv
// Assembles BEATS narrow flits into one OUT_W word; a second (assembly) buffer keeps
// input flowing while the output register is back-pressured.
module flit_deserializer
    import serdes_pkg::*;
#(
    parameter int unsigned FLIT_W    = 4,
    parameter int unsigned OUT_W     = 122,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FLIT_W-1:0] in_bits,
    input  logic              in_flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_bits,
    output logic              busy
);

    localparam int unsigned BEATS = beats(OUT_W, FLIT_W);
    localparam int unsigned CNT_W = cnt_w(BEATS);
    localparam int unsigned ASM_W = BEATS * FLIT_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    logic [ASM_W-1:0] asm_q, asm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             asm_full_q, asm_full_d;
    logic             fire, complete, accept, load;

    assign in_ready = ~asm_full_q;
    assign fire     = in_valid & in_ready;
    assign complete = fire & ~in_flush & (cnt_q == LAST);

    // Merge the incoming beat; asm_d therefore already holds a just-completed frame.
    always_comb begin
        asm_d = asm_q;
        for (int unsigned i = 0; i < BEATS; i++) begin
            if (fire && !in_flush &&
                32'(cnt_q) == (MSB_FIRST ? (BEATS - 1 - i) : i)) begin
                asm_d[i*FLIT_W +: FLIT_W] = in_bits;
            end
        end
    end

    // A held frame (asm_full) and a completing frame never coexist: in_ready is low.
    assign load       = (asm_full_q | complete) & accept;
    assign asm_full_d = (asm_full_q | complete) & ~accept;

    always_comb begin
        cnt_d = cnt_q;
        if (in_flush) begin
            cnt_d = '0;
        end else if (fire) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q      <= '0;
            asm_full_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            asm_full_q <= asm_full_d;
        end
    end

    always_ff @(posedge clock) begin
        asm_q <= asm_d;
    end

    deser_out_stage #(
        .OUT_W(OUT_W)
    ) u_out_stage (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .load_bits (asm_d[OUT_W-1:0]),
        .accept    (accept),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits)
    );

    assign busy = (cnt_q != '0) | out_valid;

endmodule

// File: tb/tb_flit_deserializer.sv
// Bench for flit_deserializer: two 4/10-bit instances (LSB and MSB order) and one default instance.
module tb_flit_deserializer;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // Small pair shares its inputs.
    logic       s_valid, s_flush, s_oready;
    logic [3:0] s_bits;
    logic       l_iready, l_ovalid, l_busy;
    logic [9:0] l_obits;
    logic       m_iready, m_ovalid, m_busy;
    logic [9:0] m_obits;

    logic         d_valid, d_flush, d_oready;
    logic [3:0]   d_bits;
    logic         d_iready, d_ovalid, d_busy;
    logic [121:0] d_obits;

    int total = 0;
    int bad   = 0;
    int d_drained = 0;

    flit_deserializer #(.FLIT_W(4), .OUT_W(10), .MSB_FIRST(1'b0)) u_lsb (
        .clock(clock), .reset(reset), .in_valid(s_valid), .in_ready(l_iready),
        .in_bits(s_bits), .in_flush(s_flush), .out_valid(l_ovalid), .out_ready(s_oready),
        .out_bits(l_obits), .busy(l_busy)
    );

    flit_deserializer #(.FLIT_W(4), .OUT_W(10), .MSB_FIRST(1'b1)) u_msb (
        .clock(clock), .reset(reset), .in_valid(s_valid), .in_ready(m_iready),
        .in_bits(s_bits), .in_flush(s_flush), .out_valid(m_ovalid), .out_ready(s_oready),
        .out_bits(m_obits), .busy(m_busy)
    );

    flit_deserializer #(.FLIT_W(4), .OUT_W(122), .MSB_FIRST(1'b0)) u_def (
        .clock(clock), .reset(reset), .in_valid(d_valid), .in_ready(d_iready),
        .in_bits(d_bits), .in_flush(d_flush), .out_valid(d_ovalid), .out_ready(d_oready),
        .out_bits(d_obits), .busy(d_busy)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Reference packing: beat i lands at bit 4*i (LSB order) or 4*(n-1-i) (MSB order),
    // then the word is truncated to out_w bits.
    function automatic logic [127:0] assemble(input logic [3:0] b[$], input bit msb,
                                              input int out_w);
        logic [127:0] acc;
        int n;
        acc = '0;
        n = b.size();
        for (int i = 0; i < n; i++) begin
            acc |= 128'(b[i]) << (4 * (msb ? (n - 1 - i) : i));
        end
        return acc & ((128'(1) << out_w) - 128'(1));
    endfunction

    // Reference models: collect accepted beats, emit a word every BEATS beats.
    logic [3:0]   l_beats[$], m_beats[$], d_beats[$];
    logic [127:0] l_exp[$], m_exp[$], d_exp[$];

    always @(negedge clock) begin
        if (reset) begin
            l_beats.delete(); l_exp.delete();
        end else begin
            if (l_ovalid) begin
                if (l_exp.size() == 0) begin
                    total++; bad++;
                    $display("FAIL lsb_spurious: out_valid=1 bits=%0h required out_valid=0", l_obits);
                end else begin
                    check("lsb_stream_word", l_obits, l_exp[0]);
                    if (s_oready) void'(l_exp.pop_front());
                end
            end
            if (s_flush) l_beats.delete();
            else if (s_valid && l_iready) begin
                l_beats.push_back(s_bits);
                if (l_beats.size() == 3) begin
                    l_exp.push_back(assemble(l_beats, 1'b0, 10));
                    l_beats.delete();
                end
            end
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            m_beats.delete(); m_exp.delete();
        end else begin
            if (m_ovalid) begin
                if (m_exp.size() == 0) begin
                    total++; bad++;
                    $display("FAIL msb_spurious: out_valid=1 bits=%0h required out_valid=0", m_obits);
                end else begin
                    check("msb_stream_word", m_obits, m_exp[0]);
                    if (s_oready) void'(m_exp.pop_front());
                end
            end
            if (s_flush) m_beats.delete();
            else if (s_valid && m_iready) begin
                m_beats.push_back(s_bits);
                if (m_beats.size() == 3) begin
                    m_exp.push_back(assemble(m_beats, 1'b1, 10));
                    m_beats.delete();
                end
            end
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            d_beats.delete(); d_exp.delete();
        end else begin
            if (d_ovalid) begin
                if (d_exp.size() == 0) begin
                    total++; bad++;
                    $display("FAIL def_spurious: out_valid=1 bits=%0h required out_valid=0", d_obits);
                end else begin
                    check("def_stream_word", d_obits, d_exp[0]);
                    if (d_oready) begin
                        void'(d_exp.pop_front());
                        d_drained++;
                    end
                end
            end
            if (d_flush) d_beats.delete();
            else if (d_valid && d_iready) begin
                d_beats.push_back(d_bits);
                if (d_beats.size() == 31) begin
                    d_exp.push_back(assemble(d_beats, 1'b0, 122));
                    d_beats.delete();
                end
            end
        end
    end

    typedef struct packed {
        logic [3:0] b0, b1, b2;
        logic [9:0] lsb, msb;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain_all(input string name);
        s_valid = 0; s_flush = 0; d_valid = 0; d_flush = 0;
        s_oready = 1; d_oready = 1;
        for (int i = 0; i < 200; i++) begin
            if (l_exp.size() == 0 && m_exp.size() == 0 && d_exp.size() == 0) break;
            tick();
        end
        check({name, "_lsb_left"}, l_exp.size(), 0);
        check({name, "_msb_left"}, m_exp.size(), 0);
        check({name, "_def_left"}, d_exp.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]   f1[$], f2[$], fq[$];
        logic [3:0]   b;
        int           stalls, start;

        tbl[0] = '{4'hA, 4'h5, 4'hF, 10'h35A, 10'h25F};
        tbl[1] = '{4'hF, 4'h5, 4'hA, 10'h25F, 10'h35A};
        tbl[2] = '{4'h0, 4'h0, 4'h0, 10'h000, 10'h000};
        tbl[3] = '{4'hF, 4'hF, 4'hF, 10'h3FF, 10'h3FF};
        tbl[4] = '{4'h1, 4'h2, 4'h3, 10'h321, 10'h123};
        tbl[5] = '{4'hC, 4'h0, 4'h4, 10'h00C, 10'h004};

        reset = 1;
        s_valid = 0; s_flush = 0; s_oready = 0; s_bits = 0;
        d_valid = 0; d_flush = 0; d_oready = 0; d_bits = 0;
        tick(); tick();
        reset = 0;
        @(negedge clock);
        check("rst_def_ovalid", d_ovalid, 0);
        check("rst_def_obits", d_obits, 0);
        check("rst_def_iready", d_iready, 1);
        check("rst_def_busy", d_busy, 0);
        check("rst_lsb_obits", l_obits, 0);
        check("rst_msb_busy", m_busy, 0);
        tick();

        // Table vectors with a free-running consumer.
        s_oready = 1;
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 3; k++) begin
                s_valid = 1;
                s_bits = (k == 0) ? tbl[r].b0 : (k == 1) ? tbl[r].b1 : tbl[r].b2;
                @(negedge clock);
                check("tbl_lsb_iready", l_iready, 1);
                check("tbl_msb_iready", m_iready, 1);
                @(posedge clock); #1;
            end
            s_valid = 0;
            @(negedge clock);
            check("tbl_lsb_valid", l_ovalid, 1);
            check("tbl_lsb_word", l_obits, tbl[r].lsb);
            check("tbl_msb_word", m_obits, tbl[r].msb);
            tick();
        end

        // Flush with a third beat in the same cycle; only the later frame survives.
        s_valid = 1; s_bits = 4'hA; tick();
        s_bits = 4'h5; tick();
        @(negedge clock);
        check("flush_busy_mid", l_busy, 1);
        @(posedge clock); #1;
        s_bits = 4'h7; s_flush = 1; tick();
        s_flush = 0; s_valid = 0;
        @(negedge clock);
        check("flush_no_word", l_ovalid, 0);
        check("flush_busy_after", l_busy, 0);
        @(posedge clock); #1;
        s_valid = 1; s_bits = 4'h1; tick();
        s_bits = 4'h2; tick();
        s_bits = 4'h3; tick();
        s_valid = 0;
        @(negedge clock);
        check("flush_lsb_word", l_obits, 10'h321);
        check("flush_msb_word", m_obits, 10'h123);
        check("flush_valid", m_ovalid, 1);
        tick();
        drain_all("flush");

        // Randomized small-pair traffic.
        for (int i = 0; i < 400; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_bits = 4'($urandom);
            s_flush = ($urandom_range(0, 15) == 0);
            s_oready = ($urandom_range(0, 1) != 0);
            tick();
        end
        drain_all("rand_small");

        // Back-pressure: two frames with the consumer stalled.
        d_oready = 0;
        f1.delete(); f2.delete();
        for (int i = 0; i < 62; i++) begin
            d_valid = 1;
            b = 4'($urandom);
            d_bits = b;
            if (i < 31) f1.push_back(b); else f2.push_back(b);
            @(negedge clock);
            check("bp_iready_during", d_iready, 1);
            @(posedge clock); #1;
        end
        d_valid = 0;
        @(negedge clock);
        check("bp_stall_iready", d_iready, 0);
        check("bp_stall_ovalid", d_ovalid, 1);
        check("bp_frame1", d_obits, assemble(f1, 1'b0, 122));
        tick(); tick(); tick();
        @(negedge clock);
        check("bp_still_stalled", d_iready, 0);
        check("bp_frame1_stable", d_obits, assemble(f1, 1'b0, 122));
        @(posedge clock); #1;
        d_oready = 1; tick();
        d_oready = 0;
        @(negedge clock);
        check("bp_after_ovalid", d_ovalid, 1);
        check("bp_after_iready", d_iready, 1);
        check("bp_frame2", d_obits, assemble(f2, 1'b0, 122));
        @(posedge clock); #1;
        d_oready = 1; tick();
        @(negedge clock);
        check("bp_empty_ovalid", d_ovalid, 0);
        check("bp_empty_busy", d_busy, 0);
        @(posedge clock); #1;

        // Streaming with a toggling consumer: no input stall, ten words.
        stalls = 0;
        start = d_drained;
        for (int i = 0; i < 310; i++) begin
            d_valid = 1;
            d_bits = 4'($urandom);
            d_oready = (i % 2 == 0);
            @(negedge clock);
            if (!d_iready) stalls++;
            @(posedge clock); #1;
        end
        d_valid = 0; d_oready = 1;
        tick(); tick(); tick();
        check("stream_stalls", stalls, 0);
        check("stream_words", d_drained - start, 10);

        // Reset with a partial frame (17 beats) and a word held.
        d_oready = 0;
        for (int i = 0; i < 48; i++) begin
            d_valid = 1; d_bits = 4'($urandom); tick();
        end
        d_valid = 0;
        @(negedge clock);
        check("pre_rst_ovalid", d_ovalid, 1);
        @(posedge clock); #1;
        reset = 1; tick();
        reset = 0;
        @(negedge clock);
        check("midrst_ovalid", d_ovalid, 0);
        check("midrst_busy", d_busy, 0);
        check("midrst_iready", d_iready, 1);
        check("midrst_obits", d_obits, 0);
        @(posedge clock); #1;
        d_oready = 1;
        fq.delete();
        for (int i = 0; i < 31; i++) begin
            b = 4'($urandom);
            fq.push_back(b);
            d_valid = 1; d_bits = b; tick();
        end
        d_valid = 0;
        @(negedge clock);
        check("postrst_valid", d_ovalid, 1);
        check("postrst_word", d_obits, assemble(fq, 1'b0, 122));
        @(posedge clock); #1;

        // Randomized default-instance traffic.
        for (int i = 0; i < 1500; i++) begin
            d_valid = ($urandom_range(0, 7) != 0);
            d_bits = 4'($urandom);
            d_flush = ($urandom_range(0, 63) == 0);
            d_oready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain_all("rand_def");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
